mio_responder: RTL and testbench
================================

# mio_responder

Memory/IO bus responder that answers the multi-cycle CPU controller's MemRead/MemWrite requests and returns the MIO_ready handshake. It decodes the CPU address into on-chip data RAM, a GPIO register pair (switches/LEDs) and a free-running timer, inserts configurable RAM wait states, and drives read data back to the CPU datapath. It sits between the CPU datapath/controller and the board I/O.

## Interface
- RAM_AW, 10: RAM word-address width; depth = 2^RAM_AW 32-bit words.
- WAIT_CYCLES, 2: extra wait cycles for RAM accesses, legal range 0..15; GPIO/timer always use 0.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- CPU_MIO  in  1  request qualifier; requests are ignored while 0.
- MemRead  in  1  read request level, held by the CPU until it samples MIO_ready.
- MemWrite  in  1  write request level, same rule.
- addr_bus  in  32  byte address; bits [1:0] ignored.
- Data_out  in  32  CPU write data.
- Data_in  out  32  read data to the CPU, registered.
- MIO_ready  out  1  one-cycle completion pulse, registered.
- switches  in  16  board switch inputs.
- LED_out  out  16  LED register.
- bus_err  out  1  sticky error flag.
- resp_state  out  2  FSM state for debug.

## Operation
- Request = CPU_MIO & (MemRead | MemWrite), sampled only in IDLE.
- Decode by addr_bus[31:28]: 4'h0 = RAM, index addr_bus[RAM_AW+1:2], upper bits ignored so the address wraps modulo depth. 4'hE = GPIO. 4'hF = timer. Any other value is unmapped. Low bits are ignored for GPIO and timer.
- On acceptance, latch the address, write data, the read/write type and the region.
- MemRead and MemWrite both high counts as an illegal request: no access is performed, bus_err is set, and the request is still completed with read data 0.
- FSM has three states:
  - IDLE (0): on a request, go to WAIT if the region is RAM and WAIT_CYCLES>0; otherwise go to DONE.
  - WAIT (1): the wait counter is loaded with WAIT_CYCLES-1 on entry and decrements each cycle. Go to DONE at the edge where the counter is 0.
  - DONE (2): MIO_ready=1 for this cycle only, then go to IDLE unconditionally.
  - Encoding 3 is unreachable and must recover to IDLE.
- The access is committed at the edge entering DONE.
  - RAM write stores Data_out. RAM read loads Data_in from the RAM.
  - GPIO write: LED_out <= Data_out[15:0]. GPIO read: Data_in <= {16'h0, switches}.
  - Timer write: load the timer with Data_out. Timer read: Data_in <= current timer value.
  - Unmapped access: no write; a read returns 0; bus_err <= 1.
- Data_in holds its value until the next read commits; writes do not change it.
- Timer is 32-bit and increments every cycle, wrapping from FFFF_FFFF to 0. If a write commits on the same edge, the written value is loaded (write wins over increment).
- bus_err is cleared only by reset.

## Timing
- Reset values: resp_state=IDLE, MIO_ready=0, Data_in=0, LED_out=0, timer=0, bus_err=0. RAM contents are not cleared.
- Latency, counting the request-visible cycle as cycle 0: MIO_ready is high in cycle WAIT_CYCLES+1 for RAM and in cycle 1 for GPIO, timer and unmapped accesses.
- Data_in is valid in the same cycle as MIO_ready.
- Back-to-back: a request present in the cycle after DONE (IDLE again) is accepted. Throughput is one access per WAIT_CYCLES+2 cycles for RAM.
- Request inputs are not re-sampled in WAIT or DONE. Dropping the request mid-WAIT does not abort the access.
- Reset asserted in WAIT or DONE: the FSM returns to IDLE immediately, no write is committed, and MIO_ready drops asynchronously.
- A timer read returns the value present before the commit edge.

## Test plan
- RAM write/read, WAIT_CYCLES=2:
  - Stimulus: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010.
  - Required: MIO_ready is high exactly in cycle 3 of each access, and the read gives Data_in=0xDEADBEEF.
- Wrap and alias (RAM_AW=10):
  - Stimulus: write 0x12345678 to 0x0000_1010, then read 0x0000_0010.
  - Required: the read returns 0x12345678.
- GPIO:
  - Stimulus: switches=0xA5C3; read 0xE000_0000, then write 0x0000_BEEF to 0xE000_0004.
  - Required: Data_in=0x0000A5C3, LED_out=0xBEEF, and both acks arrive in cycle 1.
- Timer:
  - Stimulus: write 0xFFFF_FFFE to 0xF000_0000, wait 3 cycles, then read.
  - Required: the value read reflects wrap-around through 0 (for example 0x00000001 in the exact-cycle case); write-wins behaviour is checked on the load edge.
- Error paths:
  - Stimulus: read 0x8000_0000; then assert MemRead and MemWrite together on 0x0000_0000.
  - Required: Data_in=0, MIO_ready in cycle 1, bus_err=1 and it stays sticky, and RAM word 0 is unchanged.
- Reset mid-WAIT and qualifier:
  - Stimulus: assert reset during WAIT of a RAM write; separately, issue a request with CPU_MIO=0.
  - Required: after reset there is no RAM change, the FSM is in IDLE and MIO_ready=0. With CPU_MIO=0 the FSM stays in IDLE and gives no ack.

Source files
------------

// File: rtl/mio_responder.sv
// Memory/IO bus responder for the multi-cycle CPU: decodes RAM / GPIO / timer,
// inserts RAM wait states and returns a one-cycle MIO_ready completion pulse.
module mio_responder #(
  parameter int RAM_AW      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr_bus,
  input  logic [31:0] Data_out,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  input  logic [15:0] switches,
  output logic [15:0] LED_out,
  output logic        bus_err,
  output logic [1:0]  resp_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;
  typedef enum logic [1:0] {REG_RAM = 2'd0, REG_GPIO = 2'd1, REG_TMR = 2'd2, REG_NONE = 2'd3} region_t;

  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  function automatic region_t decode(input logic [3:0] nib);
    case (nib)
      4'h0:    decode = REG_RAM;
      4'hE:    decode = REG_GPIO;
      4'hF:    decode = REG_TMR;
      default: decode = REG_NONE;
    endcase
  endfunction

  state_t              state, next_state;
  logic [3:0]          wait_cnt;
  logic [RAM_AW-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic                rd_q, wr_q;
  region_t             region_q;
  logic [31:0]         timer;
  logic [31:0]         ram [0:(1<<RAM_AW)-1];

  logic                req;
  region_t             region_d;
  logic [RAM_AW-1:0]   acc_idx;
  logic [31:0]         acc_wdata;
  logic                acc_rd, acc_wr, acc_illegal;
  region_t             acc_region;
  logic                commit;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{addr_bus[27:RAM_AW+2], addr_bus[1:0]};
  assign resp_state       = state;

  // Next state, and the access to commit: live inputs when leaving IDLE, latched ones after WAIT
  always_comb begin
    req         = CPU_MIO & (MemRead | MemWrite) & ~reset;
    region_d    = decode(addr_bus[31:28]);
    next_state  = state;
    commit      = 1'b0;
    acc_idx     = idx_q;
    acc_wdata   = wdata_q;
    acc_rd      = rd_q;
    acc_wr      = wr_q;
    acc_region  = region_q;
    case (state)
      S_IDLE: begin
        acc_idx    = addr_bus[RAM_AW+1:2];
        acc_wdata  = Data_out;
        acc_rd     = MemRead;
        acc_wr     = MemWrite;
        acc_region = region_d;
        if (req) begin
          if (region_d == REG_RAM && !(MemRead && MemWrite) && WAIT_CYCLES > 0) begin
            next_state = S_WAIT;
          end else begin
            next_state = S_DONE;
            commit     = 1'b1;
          end
        end else begin
          next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) begin
          next_state = S_DONE;
          commit     = 1'b1;
        end else begin
          next_state = S_WAIT;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    acc_illegal = acc_rd & acc_wr;
  end

  // State register, wait counter and request latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      idx_q    <= '0;
      wdata_q  <= 32'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      region_q <= REG_NONE;
    end else begin
      state <= next_state;
      if (state == S_IDLE && req) begin
        idx_q    <= addr_bus[RAM_AW+1:2];
        wdata_q  <= Data_out;
        rd_q     <= MemRead;
        wr_q     <= MemWrite;
        region_q <= region_d;
      end
      if (state == S_IDLE && next_state == S_WAIT) begin
        wait_cnt <= WAIT_LOAD;
      end else if (state == S_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // Commit: read data, LEDs, timer (write wins over increment) and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MIO_ready <= 1'b0;
      Data_in   <= 32'd0;
      LED_out   <= 16'd0;
      timer     <= 32'd0;
      bus_err   <= 1'b0;
    end else begin
      MIO_ready <= commit;
      timer     <= timer + 32'd1;
      if (commit) begin
        if (acc_illegal) begin
          bus_err <= 1'b1;
          Data_in <= 32'd0;
        end else begin
          case (acc_region)
            REG_RAM:  if (!acc_wr) Data_in <= ram[acc_idx];
            REG_GPIO: if (acc_wr) LED_out <= acc_wdata[15:0]; else Data_in <= {16'h0000, switches};
            REG_TMR:  if (acc_wr) timer <= acc_wdata; else Data_in <= timer;
            default: begin
              bus_err <= 1'b1;
              if (!acc_wr) Data_in <= 32'd0;
            end
          endcase
        end
      end
    end
  end

  // RAM storage, never reset
  always_ff @(posedge clk) begin
    if (commit && !acc_illegal && acc_wr && acc_region == REG_RAM) begin
      ram[acc_idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_mio_responder.sv
// Self-checking bench for mio_responder: transaction-level reference model,
// per-cycle output comparison, directed scenarios and randomized accesses.
module tb_mio_responder;
  localparam int AW = 10;
  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        reset, cpu_mio, mem_read, mem_write;
  logic [31:0] addr, wdata, data_in;
  logic        ready, err;
  logic [15:0] sw, led;
  logic [1:0]  st;

  always #5 clk = ~clk;

  mio_responder #(.RAM_AW(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset), .CPU_MIO(cpu_mio), .MemRead(mem_read), .MemWrite(mem_write),
    .addr_bus(addr), .Data_out(wdata), .Data_in(data_in), .MIO_ready(ready),
    .switches(sw), .LED_out(led), .bus_err(err), .resp_state(st)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  // reference model: one outstanding transaction, cycles left before its commit edge
  logic [31:0] m_ram [int];
  logic [31:0] m_timer, m_din, m_addr, m_wd;
  logic        m_din_known, m_err, m_ack, m_busy, m_rd, m_wr;
  logic [15:0] m_led;
  int          m_rem;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_timer = 32'd0; m_din = 32'd0; m_din_known = 1'b1; m_err = 1'b0;
    m_ack = 1'b0; m_busy = 1'b0; m_led = 16'd0; m_rem = 0;
  endfunction

  function automatic void model_commit(input logic [31:0] t_pre);
    int idx;
    idx = int'(m_addr[AW+1:2]);
    if (m_rd && m_wr) begin
      m_err = 1'b1; m_din = 32'd0; m_din_known = 1'b1;
    end else begin
      case (m_addr[31:28])
        4'h0: begin
          if (m_wr) m_ram[idx] = m_wd;
          else if (m_ram.exists(idx)) begin m_din = m_ram[idx]; m_din_known = 1'b1; end
          else m_din_known = 1'b0;
        end
        4'hE: if (m_wr) m_led = m_wd[15:0]; else begin m_din = {16'h0000, sw}; m_din_known = 1'b1; end
        4'hF: if (m_wr) m_timer = m_wd; else begin m_din = t_pre; m_din_known = 1'b1; end
        default: begin
          m_err = 1'b1;
          if (!m_wr) begin m_din = 32'd0; m_din_known = 1'b1; end
        end
      endcase
    end
  endfunction

  // advance the model across one rising edge using the inputs present at that edge
  function automatic void model_step();
    logic        prev_ack;
    logic [31:0] t_pre;
    if (reset) return;
    prev_ack = m_ack;
    m_ack    = 1'b0;
    t_pre    = m_timer;
    m_timer  = m_timer + 32'd1;
    if (!m_busy && !prev_ack && cpu_mio && (mem_read || mem_write)) begin
      m_busy = 1'b1; m_rd = mem_read; m_wr = mem_write; m_addr = addr; m_wd = wdata;
      m_rem  = (addr[31:28] == 4'h0 && !(mem_read && mem_write)) ? WC : 0;
    end
    if (m_busy) begin
      if (m_rem == 0) begin
        m_busy = 1'b0; m_ack = 1'b1;
        model_commit(t_pre);
      end else begin
        m_rem--;
      end
    end
  endfunction

  // per-cycle comparison of every output against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 32'(ready), 32'(m_ack));
      check("state", 32'(st), m_ack ? 32'd2 : (m_busy ? 32'd1 : 32'd0));
      check("led", 32'(led), 32'(m_led));
      check("bus_err", 32'(err), 32'(m_err));
      if (m_din_known) check("data_in", data_in, m_din);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drop_req();
    cpu_mio = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output int lat);
    cpu_mio = 1'b1; mem_read = rd; mem_write = wr; addr = a; wdata = d;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (ready) begin lat = n; break; end
    end
    drop_req();
    if (lat < 0) begin
      n_checks++; n_errors++;
      $display("FAIL ack_timeout: got no MIO_ready within 40 cycles for addr %h", a);
    end
    tick();
  endtask

  task automatic do_reset();
    drop_req();
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_state", 32'(st), 32'd0);
    check("rst_data_in", data_in, 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_bus_err", 32'(err), 32'd0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset = 1'b0; cpu_mio = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    addr = 32'd0; wdata = 32'd0; sw = 16'd0;
    model_reset();
    #1;
    do_reset();
    chk_en = 1'b1;

    // RAM write then read
    access(1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, lat); check("ram_wr_lat", 32'(lat), 32'd3);
    access(1'b1, 1'b0, 32'h0000_0010, 32'd0, lat);        check("ram_rd_lat", 32'(lat), 32'd3);
    check("ram_rd_data", data_in, 32'hDEADBEEF);

    // address wrap / alias
    access(1'b0, 1'b1, 32'h0000_1010, 32'h12345678, lat);
    access(1'b1, 1'b0, 32'h0000_0010, 32'd0, lat);
    check("alias_data", data_in, 32'h12345678);

    // GPIO
    sw = 16'hA5C3;
    access(1'b1, 1'b0, 32'hE000_0000, 32'd0, lat);        check("gpio_rd_lat", 32'(lat), 32'd1);
    check("gpio_rd_data", data_in, 32'h0000A5C3);
    access(1'b0, 1'b1, 32'hE000_0004, 32'h0000BEEF, lat); check("gpio_wr_lat", 32'(lat), 32'd1);
    check("gpio_led", 32'(led), 32'h0000BEEF);
    check("gpio_data_hold", data_in, 32'h0000A5C3);

    // timer wrap and write-wins
    access(1'b0, 1'b1, 32'hF000_0000, 32'hFFFF_FFFE, lat);
    tick(); tick();
    access(1'b1, 1'b0, 32'hF000_0000, 32'd0, lat);
    check("timer_wrap", data_in, 32'h0000_0001);
    access(1'b0, 1'b1, 32'hF000_0008, 32'h0000_0100, lat);
    access(1'b1, 1'b0, 32'hF000_0000, 32'd0, lat);
    check("timer_load", data_in, 32'h0000_0101);

    // error paths
    access(1'b0, 1'b1, 32'h0000_0000, 32'h55AA55AA, lat);
    access(1'b1, 1'b0, 32'h8000_0000, 32'd0, lat);        check("unmap_lat", 32'(lat), 32'd1);
    check("unmap_data", data_in, 32'd0);
    check("unmap_err", 32'(err), 32'd1);
    access(1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, lat); check("illegal_lat", 32'(lat), 32'd1);
    check("illegal_data", data_in, 32'd0);
    access(1'b1, 1'b0, 32'h0000_0000, 32'd0, lat);
    check("illegal_ram0", data_in, 32'h55AA55AA);
    check("err_sticky", 32'(err), 32'd1);

    // qualifier low: no acceptance
    cpu_mio = 1'b0; mem_read = 1'b1; addr = 32'hE000_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("nomio_ready", 32'(ready), 32'd0);
      check("nomio_state", 32'(st), 32'd0);
    end
    drop_req();
    tick();

    // reset during WAIT of a RAM write
    access(1'b0, 1'b1, 32'h0000_0040, 32'h11111111, lat);
    cpu_mio = 1'b1; mem_write = 1'b1; addr = 32'h0000_0040; wdata = 32'h22222222;
    tick();
    check("wait_state", 32'(st), 32'd1);
    do_reset();
    access(1'b1, 1'b0, 32'h0000_0040, 32'd0, lat);
    check("rst_wait_ram", data_in, 32'h11111111);

    // reset during DONE drops MIO_ready at once
    cpu_mio = 1'b1; mem_read = 1'b1; addr = 32'hE000_0000;
    tick();
    check("done_ready", 32'(ready), 32'd1);
    do_reset();

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      int          r;
      logic        rd, wr;
      logic [31:0] a;
      r  = int'($urandom_range(0, 9));
      wr = 1'($urandom_range(0, 1));
      rd = ~wr;
      if ($urandom_range(0, 19) == 0) begin rd = 1'b1; wr = 1'b1; end
      if (r < 5)       a = {4'h0, 16'($urandom_range(0, 3)), 12'h000} | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      else if (r == 5) a = {4'hE, 28'($urandom)};
      else if (r == 6) a = {4'hF, 28'($urandom)};
      else             a = {4'($urandom_range(1, 13)), 28'($urandom)};
      sw = 16'($urandom);
      repeat ($urandom_range(0, 2)) tick();
      access(rd, wr, a, $urandom, lat);
      check("rand_lat", 32'(lat), (a[31:28] == 4'h0 && !(rd && wr)) ? 32'(WC + 1) : 32'd1);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
